// File: rtl/case_7_arith_pkg.sv
// case_7_arith_pkg: shared FSM state, default widths and constants for the case_7 signed divider.
package case_7_arith_pkg;
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
    localparam int DIN0_W = 13;
    localparam int DIN1_W = 8;
    localparam int DOUT_W = 10;
    function automatic int work_width(input int a, input int b);
        return a + b + 1;
    endfunction
    localparam int WORK_W = work_width(DIN0_W, DIN1_W);
    localparam logic [31:0] DBZ_Q = '1;
endpackage

// File: rtl/case_7_sdiv_step.sv
// case_7_sdiv_step: one restoring division iteration (shift, trial subtract, select).
module case_7_sdiv_step
    import case_7_arith_pkg::*;
#(
    parameter int din0_WIDTH = DIN0_W,
    parameter int din1_WIDTH = DIN1_W,
    localparam int WW = work_width(din0_WIDTH, din1_WIDTH)
) (
    input  logic [WW-1:0]         work_in,
    input  logic [din1_WIDTH-1:0] dabs,
    output logic [WW-1:0]         work_out
);
    logic [WW-1:0]         sh;
    logic [din1_WIDTH+1:0] diff;
    always_comb begin
        sh = work_in << 1;
        diff = {1'b0, sh[WW-1:din0_WIDTH]} - {2'b0, dabs};
        work_out = diff[din1_WIDTH+1] ? sh : {diff[din1_WIDTH:0], sh[din0_WIDTH-1:1], 1'b1};
    end
endmodule

// File: rtl/case_7_sdiv_13s_8s_10_seq.sv
// case_7_sdiv_13s_8s_10_seq: sequential restoring signed divider, C truncation semantics.
// Define CASE_7_SDIV_DBZ_FLAG_EN to add the registered divide-by-zero flag output dbz.
module case_7_sdiv_13s_8s_10_seq
    import case_7_arith_pkg::*;
#(
    parameter int ID         = 1,
    parameter int din0_WIDTH = DIN0_W,
    parameter int din1_WIDTH = DIN1_W,
    parameter int dout_WIDTH = DOUT_W
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [dout_WIDTH-1:0] dout,
    output logic [din1_WIDTH-1:0] rem
`ifdef CASE_7_SDIV_DBZ_FLAG_EN
    ,
    output logic                  dbz
`endif
);
    localparam int WW = work_width(din0_WIDTH, din1_WIDTH);
    localparam int CW = $clog2(din0_WIDTH);
    state_t state, state_nx;
    logic [CW-1:0] cnt;
    logic [WW-1:0] work, work_nx;
    logic [din1_WIDTH-1:0] dabs, d0lo, rm, rs;
    logic [din0_WIDTH-1:0] a0;
    logic [dout_WIDTH-1:0] qm, qs;
    logic s0, s1, dz, accept;

    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign accept    = in_valid && in_ready;
    assign a0 = din0[din0_WIDTH-1] ? -din0 : din0;
    assign qm = work[dout_WIDTH-1:0];
    assign rm = work[din0_WIDTH+din1_WIDTH-1:din0_WIDTH];
    assign qs = (s0 ^ s1) ? -qm : qm;
    assign rs = s0 ? -rm : rm;

    case_7_sdiv_step #(.din0_WIDTH(din0_WIDTH), .din1_WIDTH(din1_WIDTH)) u_step (
        .work_in(work),
        .dabs(dabs),
        .work_out(work_nx)
    );

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = in_valid ? CALC : IDLE;
            CALC:    state_nx = (cnt == '0) ? FIX : CALC;
            FIX:     state_nx = DONE;
            default: state_nx = out_ready ? IDLE : DONE;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            work  <= '0;
            dabs  <= '0;
            d0lo  <= '0;
            s0    <= 1'b0;
            s1    <= 1'b0;
            dz    <= 1'b0;
            dout  <= '0;
            rem   <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                work <= {{(din1_WIDTH+1){1'b0}}, a0};
                dabs <= din1[din1_WIDTH-1] ? -din1 : din1;
                d0lo <= din0[din1_WIDTH-1:0];
                s0   <= din0[din0_WIDTH-1];
                s1   <= din1[din1_WIDTH-1];
                dz   <= din1 == '0;
                cnt  <= CW'(din0_WIDTH - 1);
            end else if (state == CALC) begin
                work <= work_nx;
                cnt  <= cnt - 1'b1;
            end else if (state == FIX) begin
                // a zero divisor still runs the full iteration; its result is replaced here
                dout <= dz ? DBZ_Q[dout_WIDTH-1:0] : qs;
                rem  <= dz ? d0lo : rs;
            end
        end
    end

`ifdef CASE_7_SDIV_DBZ_FLAG_EN
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n)
            dbz <= 1'b0;
        else if (state == FIX)
            dbz <= dz;
        else if (state == DONE && out_ready)
            dbz <= 1'b0;
    end
`endif
endmodule
